// File: rtl/fib_pkg.sv
// Shared types and default widths for the fib request controller and its bench.
package fib_pkg;

  localparam int FIB_IN_W  = 6;
  localparam int FIB_OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [FIB_IN_W-1:0]  n;
    logic [FIB_OUT_W-1:0] result;
    logic                 overflow;
    logic                 timeout;
  } fib_rsp_t;

endpackage

// File: rtl/fib_req_ctrl_if.sv
// Request, core and response signal bundle for fib_req_ctrl.
// slave is the controller's view; master is the environment driving requests and the core.
interface fib_req_ctrl_if
  import fib_pkg::*;
#(
  parameter int IN_W  = FIB_IN_W,
  parameter int OUT_W = FIB_OUT_W
);

  logic             req_valid;
  logic             req_ready;
  logic [IN_W-1:0]  req_n;

  logic             fib_go;
  logic [IN_W-1:0]  fib_n;
  logic [OUT_W-1:0] fib_result;
  logic             fib_overflow;
  logic             fib_done;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [IN_W-1:0]  rsp_n;
  logic [OUT_W-1:0] rsp_result;
  logic             rsp_overflow;
  logic             rsp_timeout;

  modport slave (
    input  req_valid, req_n,
    output req_ready,
    output fib_go, fib_n,
    input  fib_result, fib_overflow, fib_done,
    output rsp_valid, rsp_n, rsp_result, rsp_overflow, rsp_timeout,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_n,
    input  req_ready,
    input  fib_go, fib_n,
    output fib_result, fib_overflow, fib_done,
    input  rsp_valid, rsp_n, rsp_result, rsp_overflow, rsp_timeout,
    output rsp_ready
  );

endinterface

// File: rtl/fib_timeout_cnt.sv
// Saturating job timer: cleared on issue, counts while waiting, flags expiry.
module fib_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the increment that lands on LAST, so the response appears
  // exactly TIMEOUT_CYCLES cycles after the go cycle.
  assign o_expired = i_enable && (r_count >= (LAST - 1'b1));

endmodule

// File: rtl/fib_req_ctrl.sv
// Request/response front-end for the fib core with stale-done guard and completion timeout.
// Optional hit counters are compiled in with FIB_REQ_CTRL_STATS_EN.
module fib_req_ctrl
  import fib_pkg::*;
#(
  parameter int INPUT_WIDTH    = FIB_IN_W,
  parameter int OUTPUT_WIDTH   = FIB_OUT_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  fib_req_ctrl_if.slave bus
`ifdef FIB_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]   stat_done_cnt,
  output logic [15:0]   stat_ovf_cnt,
  output logic [15:0]   stat_to_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]              r_state;
  logic                    r_req_ready;
  logic                    r_fib_go;
  logic [INPUT_WIDTH-1:0]  r_fib_n;
  logic                    r_rsp_valid;
  logic [INPUT_WIDTH-1:0]  r_rsp_n;
  logic [OUTPUT_WIDTH-1:0] r_rsp_result;
  logic                    r_rsp_overflow;
  logic                    r_rsp_timeout;
  logic                    r_armed;

  logic w_req_fire;
  logic w_rsp_fire;
  logic w_done_qual;
  logic w_timer_clear;
  logic w_timer_en;
  logic w_expired;

  assign w_req_fire    = bus.req_valid && r_req_ready;
  assign w_rsp_fire    = r_rsp_valid && bus.rsp_ready;
  // A done level left over from the previous job only counts after it has been seen low.
  assign w_done_qual   = bus.fib_done && r_armed;
  assign w_timer_clear = (r_state == ST_ISSUE);
  assign w_timer_en    = (r_state == ST_WAIT);

  fib_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_req_ready    <= 1'b1;
      r_fib_go       <= 1'b0;
      r_fib_n        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_n        <= '0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_timeout  <= 1'b0;
      r_armed        <= 1'b0;
    end else begin
      r_fib_go <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_fib_n     <= bus.req_n;
            r_rsp_n     <= bus.req_n;
            r_req_ready <= 1'b0;
            r_fib_go    <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_armed <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.fib_done) begin
            r_armed <= 1'b1;
          end
          if (w_done_qual) begin
            r_rsp_result   <= bus.fib_result;
            r_rsp_overflow <= bus.fib_overflow;
            r_rsp_timeout  <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end else if (w_expired) begin
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_timeout  <= 1'b1;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.fib_go       = r_fib_go;
  assign bus.fib_n        = r_fib_n;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_n        = r_rsp_n;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_overflow = r_rsp_overflow;
  assign bus.rsp_timeout  = r_rsp_timeout;

`ifdef FIB_REQ_CTRL_STATS_EN
  // Bit order: 0 = completed, 1 = overflowed, 2 = timed out.
  logic [2:0] w_stat_inc;

  assign w_stat_inc = {w_rsp_fire && r_rsp_timeout,
                       w_rsp_fire && r_rsp_overflow,
                       w_rsp_fire && !r_rsp_timeout};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [15:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_stat_inc[gi] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign stat_done_cnt = g_stat[0].r_cnt;
  assign stat_ovf_cnt  = g_stat[1].r_cnt;
  assign stat_to_cnt   = g_stat[2].r_cnt;
`endif

endmodule

// File: doc/fib_req_ctrl.md
Name: fib_req_ctrl

Overview:
- Upstream request/response front-end for the fib core.
- Accepts n values over a valid/ready request channel and issues each to the core as a one-cycle go pulse.
- Holds fib_n stable, waits for a fresh done, and captures result/overflow into a registered valid/ready response channel.
- Adds a completion timeout so a hung core cannot stall the request stream.

Parameters:
- INPUT_WIDTH, 6: width of n; must match the core.
- OUTPUT_WIDTH, 32: width of result; must match the core.
- TIMEOUT_CYCLES, 1024: cycles after go before a request is abandoned; must be ≥4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_n  in  INPUT_WIDTH  requested index
- fib_go  out  1  one-cycle start pulse to core
- fib_n  out  INPUT_WIDTH  index to core, held stable for the whole job
- fib_result  in  OUTPUT_WIDTH  core result
- fib_overflow  in  1  core overflow flag
- fib_done  in  1  core done, level; may still be high from the previous job
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_n  out  INPUT_WIDTH  echo of the request index
- rsp_result  out  OUTPUT_WIDTH  captured result; 0 on timeout
- rsp_overflow  out  1  captured overflow; 0 on timeout
- rsp_timeout  out  1  job abandoned

Behaviour:
- Reset (async, any state): state=IDLE. req_ready=1; fib_go=0; fib_n=0; rsp_valid=0; rsp_n/rsp_result/rsp_overflow/rsp_timeout=0; timer=0; armed=0.
- All outputs are registered. req_ready is high only in IDLE.
- IDLE:
  - On handshake, latch req_n into fib_n and rsp_n, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - fib_go=1.
  - Clear timer and armed, then go to WAIT.
  - fib_go is never high in any other state. The core restarts on every go, so go must never repeat mid-job.
- WAIT:
  - fib_go=0; timer increments every cycle.
  - Stale-done guard: armed sets on the first cycle fib_done==0 is sampled. fib_done==1 with armed==0 is ignored.
  - fib_done==1 with armed==1: capture fib_result and fib_overflow, set rsp_timeout=0, go to RESP.
  - Timeout: if timer reaches TIMEOUT_CYCLES-1 with no qualified done, go to RESP with rsp_result=0, rsp_overflow=0, rsp_timeout=1.
  - If qualified done and timeout coincide, done wins.
- RESP:
  - rsp_valid=1; response fields are stable until the handshake.
  - On rsp_ready, go to IDLE (rsp_valid=0, req_ready=1 next cycle). Back-to-back requests cannot overlap.
- Minimum latency, request accept at cycle T:
  - fib_go at T+1.
  - Earliest rsp_valid at T+1+k+1, where k is the core's cycles to a qualified done.
- fib_n is unchanged from ISSUE until the next accepted request, so the core's later re-reads of n stay valid.
- Widths: timer is $clog2(TIMEOUT_CYCLES) bits and saturates at the compare; it never wraps.
- req_valid while not IDLE: ignored, no handshake. rsp_ready while rsp_valid==0: ignored.

Optional Feature:
- Macro FIB_REQ_CTRL_STATS_EN.
- When defined, three extra outputs exist, each 16-bit, cleared by rst and saturating at 16'hFFFF:
  - stat_done_cnt: increments on a response handshake with rsp_timeout=0.
  - stat_ovf_cnt: increments on a response handshake with rsp_overflow=1.
  - stat_to_cnt: increments on a response handshake with rsp_timeout=1.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fib_pkg holds:
  - ctrl_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - default width localparams FIB_IN_W=6 and FIB_OUT_W=32;
  - packed struct fib_rsp_t {n, result, overflow, timeout}.
- One sub-module, fib_timeout_cnt: clear/enable/expired with a TIMEOUT_CYCLES parameter. Instantiated once.

Test Plan:
- Stub core: done drops 2 cycles after go, rises 5 cycles later, result=n*3. req_n=7 -> one fib_go pulse, fib_n=7 held, rsp_result=21, rsp_overflow=0, rsp_timeout=0, rsp_n=7.
- Stub holds fib_done=1 from the prior job while a new request n=4 is issued -> stale done ignored; response arrives only after done falls then rises; rsp_result=12.
- Stub never raises done, TIMEOUT_CYCLES=16 -> rsp_timeout=1 and rsp_result=0 exactly 16 cycles after the go cycle; next request issues a fresh go.
- Backpressure: rsp_ready low for 10 cycles, stub overflow=1 -> rsp fields stable, req_ready=0 and no fib_go throughout; overflow=1 delivered on handshake.
- rst asserted mid-WAIT -> all outputs return to reset values asynchronously; req_ready=1 after release; a new request n=2 completes normally.
- With FIB_REQ_CTRL_STATS_EN: 3 normal jobs, 1 with overflow, 1 timeout -> stat_done_cnt=3, stat_ovf_cnt=1, stat_to_cnt=1.
